// File: rtl/sys_defs.sv
// Shared core definitions: datapath types, physical-register and multiplier pipeline geometry.
package sys_defs;

  localparam int unsigned XLEN           = 32;
  localparam int unsigned PHYS_REG_WIDTH = 6;
  localparam int unsigned MULT_STAGES    = 8;
  localparam int unsigned MULT_PROD_W    = 64;
  localparam int unsigned MULT_STAGE_W   = MULT_PROD_W / MULT_STAGES;

  typedef logic [XLEN-1:0] DATA;

  typedef enum logic [2:0] {
    M_MUL    = 3'd0,
    M_MULH   = 3'd1,
    M_MULHSU = 3'd2,
    M_MULHU  = 3'd3
  } MULT_FUNC;

  // One in-flight multiply: running sum, shifted multiplicand, remaining multiplier bits.
  typedef struct packed {
    logic                      valid;
    MULT_FUNC                  func;
    logic [PHYS_REG_WIDTH-1:0] tag;
    logic [MULT_PROD_W-1:0]    acc;
    logic [MULT_PROD_W-1:0]    mcand;
    logic [MULT_PROD_W-1:0]    mplier;
  } MULT_PACKET;

  // Unused encodings fall back to the low-word multiply.
  function automatic MULT_FUNC decode_func(input logic [2:0] raw);
    MULT_FUNC f;
    case (raw)
      3'd1:    f = M_MULH;
      3'd2:    f = M_MULHSU;
      3'd3:    f = M_MULHU;
      default: f = M_MUL;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/mult_fu_if.sv
// Issue-side and CDB-side handshake bundle of the multiply function unit.
interface mult_fu_if
  import sys_defs::*;
#(
  parameter int unsigned TAG_W = PHYS_REG_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_func;
  DATA              in_rs1;
  DATA              in_rs2;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  DATA              out_result;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_func, in_rs1, in_rs2, in_tag, flush, out_ready,
    input  in_ready, out_valid, out_result, out_tag
  );

  modport slave (
    input  in_valid, in_func, in_rs1, in_rs2, in_tag, flush, out_ready,
    output in_ready, out_valid, out_result, out_tag
  );

endinterface

// File: rtl/mult_stage.sv
// One registered multiplier stage: folds W multiplier bits into the accumulator.
module mult_stage
  import sys_defs::*;
#(
  parameter int unsigned W = MULT_STAGE_W
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       stall,
  input  logic       flush,
  input  MULT_PACKET in_pkt,
  output MULT_PACKET out_pkt
);

  MULT_PACKET             nxt;
  MULT_PACKET             data_q;
  logic                   valid_q;
  logic [MULT_PROD_W-1:0] pp;

  // Partial product of the low W multiplier bits; everything is modulo 2^64.
  always_comb begin
    pp          = in_pkt.mcand * MULT_PROD_W'(in_pkt.mplier[W-1:0]);
    nxt         = in_pkt;
    nxt.acc     = in_pkt.acc + pp;
    nxt.mcand   = in_pkt.mcand << W;
    nxt.mplier  = in_pkt.mplier >> W;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (!stall) begin
      valid_q <= in_pkt.valid;
    end
  end

  // Payload only moves with a live op; bubbles leave the old data in place.
  always_ff @(posedge clock) begin
    if (!stall && in_pkt.valid) begin
      data_q <= nxt;
    end
  end

  always_comb begin
    out_pkt       = data_q;
    out_pkt.valid = valid_q;
  end

endmodule

// File: rtl/mult_fu.sv
// Pipelined RV32M multiply unit: operand extension, STAGES partial-product stages, result register.
module mult_fu
  import sys_defs::*;
#(
  parameter int unsigned STAGES = MULT_STAGES,
  parameter int unsigned TAG_W  = PHYS_REG_WIDTH
) (
  input logic      clock,
  input logic      reset_n,
  mult_fu_if.slave bus
);

  localparam int unsigned W = MULT_PROD_W / STAGES;

  if ((STAGES == 0) || ((MULT_PROD_W % STAGES) != 0) || (TAG_W > PHYS_REG_WIDTH)) begin : g_param_check
    $error("mult_fu: STAGES must divide 64 and TAG_W must fit PHYS_REG_WIDTH");
  end

  MULT_PACKET       entry;
  MULT_PACKET       stage_out [STAGES];
  MULT_FUNC         func;
  logic             stall;
  logic             out_valid_q;
  DATA              out_result_q;
  logic [TAG_W-1:0] out_tag_q;
  DATA              res_sel;

  assign stall = out_valid_q & ~bus.out_ready;

  // Extend operands to 64 bits so one unsigned 64x64 low product covers every variant.
  always_comb begin
    func         = decode_func(bus.in_func);
    entry.valid  = bus.in_valid & ~stall & ~bus.flush;
    entry.func   = func;
    entry.tag    = PHYS_REG_WIDTH'(bus.in_tag);
    entry.acc    = '0;
    entry.mcand  = (func == M_MULHU) ? {32'h0, bus.in_rs1}
                                     : {{32{bus.in_rs1[31]}}, bus.in_rs1};
    entry.mplier = ((func == M_MULHSU) || (func == M_MULHU)) ? {32'h0, bus.in_rs2}
                                                             : {{32{bus.in_rs2[31]}}, bus.in_rs2};
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      mult_stage #(.W(W)) u_stage (
        .clock   (clock),
        .reset_n (reset_n),
        .stall   (stall),
        .flush   (bus.flush),
        .in_pkt  (entry),
        .out_pkt (stage_out[k])
      );
    end else begin : g_rest
      mult_stage #(.W(W)) u_stage (
        .clock   (clock),
        .reset_n (reset_n),
        .stall   (stall),
        .flush   (bus.flush),
        .in_pkt  (stage_out[k-1]),
        .out_pkt (stage_out[k])
      );
    end
  end

  always_comb begin
    res_sel = (stage_out[STAGES-1].func == M_MUL) ? stage_out[STAGES-1].acc[31:0]
                                                  : stage_out[STAGES-1].acc[63:32];
  end

  // Output register holds under back-pressure; flush drops it even while stalled.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
    end else if (bus.flush) begin
      out_valid_q  <= 1'b0;
    end else if (!stall) begin
      out_valid_q  <= stage_out[STAGES-1].valid;
      if (stage_out[STAGES-1].valid) begin
        out_result_q <= res_sel;
        out_tag_q    <= TAG_W'(stage_out[STAGES-1].tag);
      end
    end
  end

  assign bus.in_ready   = ~stall;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign bus.out_tag    = out_tag_q;

endmodule

// File: doc/mult_fu.md
Name: mult_fu

Overview:
- Pipelined integer multiply function unit for the RV32M MUL, MULH, MULHSU and MULHU instructions. It is the FU_MULT execute stage.
- Sits downstream of the reservation station issue port, which supplies operands, function and destination tag.
- Sits upstream of the CDB/complete stage, which consumes the result, tag and valid.
- Throughput is one op per cycle. Latency is MULT_STAGES cycles. Results stall in place under back-pressure and are squashed on flush.

Parameters:
- STAGES, default MULT_STAGES (8): pipeline depth. Must divide 64. Each stage consumes 64/STAGES multiplier bits.
- TAG_W, default PHYS_REG_WIDTH (6): width of the destination physical-register tag.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  issue presents an op this cycle
- in_ready  out  1  unit accepts the op this cycle
- in_func  in  3  MULT_FUNC (M_MUL, M_MULH, M_MULHSU, M_MULHU)
- in_rs1  in  32  operand A (DATA)
- in_rs2  in  32  operand B (DATA)
- in_tag  in  TAG_W  destination tag
- flush  in  1  squash all in-flight ops (branch mispredict)
- out_valid  out  1  result available at the last stage
- out_ready  in  1  CDB grants the result this cycle
- out_result  out  32  32-bit result (DATA)
- out_tag  out  TAG_W  tag of the result

Behaviour:
- Reset (reset_n low, asynchronous): all stage valid bits are 0, so out_valid=0 and in_ready=1. out_result and out_tag are 0. Data registers in stages need no reset.
- stall = out_valid & ~out_ready.
  - in_ready = ~stall.
  - While stall is high, every stage holds its contents and no new op enters.
- Accept: an op enters stage 0 on a rising edge when in_valid & in_ready & ~flush.
- Latency:
  - An op accepted at edge t is presented on out_valid/out_result at edge t+STAGES if no stall occurs.
  - Each stall cycle adds one cycle.
- Bubbles: when an invalid stage advances, it writes valid=0. The pipe is not bubble-collapsing; all stages stall together.
- Operand extension at entry, to 64 bits:
  - MUL and MULH: A signed, B signed.
  - MULHSU: A signed, B unsigned.
  - MULHU: A unsigned, B unsigned.
- Arithmetic:
  - Stage k adds the partial products of extended-B bits [(k+1)*W-1 : k*W] to a 64-bit accumulator, where W=64/STAGES.
  - The accumulator is taken modulo 2^64. This gives the exact signed or unsigned 64-bit product.
  - Each stage carries func, tag, accumulator, shifted A and remaining B.
- Result select at the last stage: MUL takes product[31:0]. MULH, MULHSU and MULHU take product[63:32].
- Flush:
  - All stage valid bits clear on the next edge, including the last stage, even if stalled.
  - in_valid during a flush cycle is ignored.
  - out_valid is 0 the cycle after flush.
- Flush and out_ready in the same cycle: the result is presented and consumed that cycle. The consumer is responsible for discarding it under flush.
- Reset mid-operation: all valid bits clear immediately. No result appears later.
- out_tag and out_result must be stable while out_valid & ~out_ready.
- Illegal in_func encodings (4..7) are treated as M_MUL.

Decomposition:
- Shared package sys_defs already holds MULT_FUNC, DATA, PHYS_REG_WIDTH and MULT_STAGES.
- Add a MULT_PACKET struct to sys_defs: valid, MULT_FUNC func, tag, 64-bit acc, 64-bit mcand, 64-bit mplier.
- Add the per-stage width constant to sys_defs.
- One sub-module, mult_stage, implements a single registered stage: partial-product add, shift, hold-on-stall, clear-on-flush.
  - mult_fu generates STAGES instances of it.
  - mult_fu also contains the operand extension and result select.

Test Plan:
1. Reset, then MUL rs1=3, rs2=0xFFFFFFFE (-2), tag=5, out_ready=1 -> out_valid rises exactly 8 cycles after accept with out_result=0xFFFFFFFA, out_tag=5.
2. Back-to-back issue with out_ready=1: MULH 0x80000000*0x80000000 tag=1, then MULHU 0xFFFFFFFF*0xFFFFFFFF tag=2, then MULHSU 0xFFFFFFFF*0xFFFFFFFF tag=3 -> results appear on consecutive cycles as 0x40000000, 0xFFFFFFFE, 0xFFFFFFFF with tags 1, 2, 3.
3. Hold out_ready=0 for 5 cycles when the first of two pipelined ops reaches output -> in_ready=0 and out_result/out_tag held constant for those 5 cycles; both ops then drain in order with no loss or duplication.
4. Issue 4 ops, then assert flush for 1 cycle with in_valid=1 -> no out_valid ever asserts for the flushed ops or the flush-cycle op; an op issued the next cycle completes normally 8 cycles later.
5. Drop reset_n asynchronously between clock edges with 3 ops in flight -> out_valid=0 and in_ready=1 immediately; no output appears after reset is released.
6. Random regression of 10k ops against a reference 64-bit product, with random in_valid, out_ready and flush -> every accepted, unflushed op produces exactly one correct result in issue order.
